// File: rtl/seven_seg_scanner_pkg.sv
// Shared display definitions: digit code constants, segment constants and
// the scanner state encoding. Imported by every display block.
package display_pkg;

  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_DASH  = 4'd11;
  localparam logic [3:0] CODE_A     = 4'd12;
  localparam logic [3:0] CODE_P     = 4'd13;
  localparam logic [3:0] CODE_E     = 4'd14;

  // Segments are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam int unsigned DIGITS = 6;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_e;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display bus: digit codes, decimal-point mask and alarm flag flow from the
// clock/alarm wrappers (master) into the scanner (slave); segment, decimal
// point and anode drives flow back out to the display pins.
//   bch0..bch5  4-bit digit codes, bch0 leftmost
//   dp_mask     per-digit decimal-point request, active-high
//   alarm_alert flash enable
//   seg         {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   digit_en    digit anodes, active-low
interface seven_seg_scanner_if;
  import display_pkg::*;

  logic [3:0]        bch0;
  logic [3:0]        bch1;
  logic [3:0]        bch2;
  logic [3:0]        bch3;
  logic [3:0]        bch4;
  logic [3:0]        bch5;
  logic [DIGITS-1:0] dp_mask;
  logic              alarm_alert;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] digit_en;

  modport master (
    output bch0, bch1, bch2, bch3, bch4, bch5, dp_mask, alarm_alert,
    input  seg, dp, digit_en
  );

  modport slave (
    input  bch0, bch1, bch2, bch3, bch4, bch5, dp_mask, alarm_alert,
    output seg, dp, digit_en
  );

endinterface

// File: rtl/seven_seg_scanner_decode.sv
// seg7_decode: combinational 4-bit digit code to active-low 7-segment
// pattern {g,f,e,d,c,b,a}.
//   code_i  digit code (0-9 glyphs, 10 blank, 11 dash, 12 A, 13 P, 14 E, 15 blank)
//   seg_o   segment pattern, active-low
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      4'd0:      seg_o = 7'h40;
      4'd1:      seg_o = 7'h79;
      4'd2:      seg_o = 7'h24;
      4'd3:      seg_o = 7'h30;
      4'd4:      seg_o = 7'h19;
      4'd5:      seg_o = 7'h12;
      4'd6:      seg_o = 7'h02;
      4'd7:      seg_o = 7'h78;
      4'd8:      seg_o = 7'h00;
      4'd9:      seg_o = 7'h10;
      CODE_DASH: seg_o = 7'h3F;
      CODE_A:    seg_o = 7'h08;
      CODE_P:    seg_o = 7'h0C;
      CODE_E:    seg_o = 7'h06;
      default:   seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Six-digit time-multiplexed 7-segment scanner with a blank gap before each
// digit, once-per-frame snapshot of the digit codes, and frame-rate flashing
// while the alarm is active.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      display bus (slave side): codes/mask/alarm in, seg/dp/digit_en out
module seven_seg_scanner
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned FLASH_FRAMES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  seven_seg_scanner_if.slave  bus
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned FW      = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  scan_state_e                state_q;
  logic [CW-1:0]              cnt_q;
  logic [2:0]                 idx_q;
  logic [DIGITS-1:0][3:0]     snap_q;
  logic [DIGITS-1:0]          snap_dp_q;
  logic                       flash_off_q;
  logic [FW-1:0]              frame_q;
  logic [6:0]                 seg_q;
  logic                       dp_q;
  logic [DIGITS-1:0]          digit_en_q;

  logic                       capture;
  logic                       blank_done;
  logic                       drive_done;
  logic                       frame_end;
  logic [3:0]                 code_d;
  logic                       dp_req_d;
  logic [6:0]                 dec_seg;

  assign capture    = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
  assign blank_done = (state_q == ST_BLANK) && (cnt_q == CW'(BLANK_CYCLES - 1));
  assign drive_done = (state_q == ST_DRIVE) && (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_end  = drive_done && (idx_q == 3'(DIGITS - 1));

  // With a one-cycle blank gap the capture edge is also the DRIVE entry edge
  // of digit 0, so the freshly captured inputs are used directly there.
  always_comb begin
    code_d   = snap_q[idx_q];
    dp_req_d = snap_dp_q[idx_q];
    if (capture) begin
      code_d   = bus.bch0;
      dp_req_d = bus.dp_mask[0];
    end
  end

  seg7_decode u_decode (
    .code_i (code_d),
    .seg_o  (dec_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      snap_q      <= {DIGITS{CODE_BLANK}};
      snap_dp_q   <= '0;
      flash_off_q <= 1'b0;
      frame_q     <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      digit_en_q  <= '1;
    end else begin
      if (capture) begin
        snap_q    <= {bus.bch5, bus.bch4, bus.bch3, bus.bch2, bus.bch1, bus.bch0};
        snap_dp_q <= bus.dp_mask;
      end

      case (state_q)
        ST_BLANK: begin
          if (blank_done) begin
            state_q    <= ST_DRIVE;
            cnt_q      <= '0;
            digit_en_q <= ~(DIGITS'(1) << idx_q);
            if (flash_off_q) begin
              seg_q <= SEG_OFF;
              dp_q  <= 1'b1;
            end else begin
              seg_q <= dec_seg;
              dp_q  <= ~dp_req_d;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (drive_done) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            idx_q      <= (idx_q == 3'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            digit_en_q <= '1;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_BLANK;
          cnt_q   <= '0;
        end
      endcase

      // Holding both at zero while idle makes every alarm start visible.
      if (!bus.alarm_alert) begin
        frame_q     <= '0;
        flash_off_q <= 1'b0;
      end else if (frame_end) begin
        if (frame_q == FW'(FLASH_FRAMES - 1)) begin
          frame_q     <= '0;
          flash_off_q <= ~flash_off_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.digit_en = digit_en_q;

endmodule
